// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Performs one shift-add (multiply) or restoring shift-subtract (divide)
// step per cycle for 32 cycles, then sign-corrects the result into HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Control state (reset)
    state_t           r_state;
    logic [CW-1:0]    r_cnt;

    // Datapath state (no reset needed; always loaded before use)
    logic [2*WIDTH-1:0] r_acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_opb;     // multiplicand magnitude or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;   // negate product / quotient at the end
    logic               r_neg_r;   // negate remainder at the end

    // Magnitude of a value, treating it as two's complement when requested.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's complement negation, single width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's complement negation, double width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Operand decode for the start cycle
    logic             w_signed;
    logic             w_div;
    logic             w_sa;
    logic             w_sb;
    logic             w_div0;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = ~op[0];
    assign w_div    = op[1];
    assign w_sa     = w_signed & data_in1[WIDTH-1];
    assign w_sb     = w_signed & data_in2[WIDTH-1];
    assign w_div0   = w_div && (data_in2 == '0);
    assign w_a_mag  = abs_val(data_in1, w_signed);
    assign w_b_mag  = abs_val(data_in2, w_signed);

    // One iteration step
    logic [WIDTH:0]       w_add;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_step;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Multiply: add multiplicand into upper half when LSB set, then shift right.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_add, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};

    // Divide: shift next dividend bit into remainder, subtract divisor if it fits.
    // The shifted remainder is below twice the divisor, so the difference fits in WIDTH bits.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_opb});
    assign w_rem_step = w_shift[WIDTH-1:0] - r_opb;
    assign w_div_next = w_ge ? {w_rem_step,          r_acc[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // Sign-corrected final results, taken from the last iteration's output
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign w_prod   = neg_2w(w_acc_next, r_neg_q);
    assign w_quo    = neg_w(w_acc_next[WIDTH-1:0], r_neg_q);
    assign w_rem    = neg_w(w_acc_next[2*WIDTH-1:WIDTH], r_neg_r);
    assign w_fin_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_fin_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    // Datapath registers: load magnitudes on start, iterate while calculating.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
            r_opb    <= w_b_mag;
            r_is_div <= w_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
        end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_next;
        end
    end

    // Control FSM with registered busy/done and the architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if (w_div0) begin
                            // Divide by zero completes immediately with fixed results.
                            hi      <= data_in1;
                            lo      <= '1;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        if (hi_we) hi <= data_in1;
                        if (lo_we) lo <= data_in1;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        hi      <= w_fin_hi;
                        lo      <= w_fin_lo;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences and randomized operations against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .data_in1(d1), .data_in2(d2), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output int elat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        elat = 33;
        eh   = '0;
        el   = '0;
        case (o)
            2'd0: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    eh   = a;
                    el   = 32'hFFFF_FFFF;
                    elat = 1;
                end else if (o == 2'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Issue one operation and check latency, busy duration, hold behaviour and results.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input bit inject);
        logic [31:0] hi0, lo0;
        int cyc, busy_cnt;
        hi0 = hi;
        lo0 = lo;
        op = o; d1 = a; d2 = b; start = 1'b1;
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        d1 = $urandom; d2 = $urandom; op = 2'($urandom);
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            if (cyc == 5) begin
                chk({name, " hold hi"}, hi, hi0);
                chk({name, " hold lo"}, lo, lo0);
            end
            if (inject && cyc == 21) chk({name, " hi after busy write"}, hi, hi0);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (inject && cyc == 10) begin
                start = 1'b1; op = 2'd3; d1 = 32'd5; d2 = 32'd0;
            end
            if (inject && cyc == 20) begin
                hi_we = 1'b1; d1 = 32'h1234;
            end
            tick();
            cyc++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({name, " latency"}, cyc, elat);
        chk({name, " busy cycles"}, busy_cnt + (busy ? 1 : 0), elat);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        tick();
        chk({name, " done pulse ends"}, {busy, done}, 2'b00);
        chk({name, " hi kept"}, hi, eh);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, reh, rel;
        int          rlat, dcnt;

        vecs[0]  = '{"multu max",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[1]  = '{"mult -3x7",    2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[2]  = '{"div -7/2",     2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{"divu 100/7",   2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[4]  = '{"divu 5/0",     2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
        vecs[5]  = '{"div min/-1",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        vecs[6]  = '{"div 7/-2",     2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[7]  = '{"mult min^2",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         33};
        vecs[8]  = '{"mult -1x-1",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         33};
        vecs[9]  = '{"div -7/0",     2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
        vecs[10] = '{"divu big/3",   2'd3, 32'hFFFF_FFFF, 32'd3,         32'd0,         32'h5555_5555, 33};
        vecs[11] = '{"multu 0x5",    2'd1, 32'd0,         32'd5,         32'd0,         32'd0,         33};

        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'd0; d1 = '0; d2 = '0;
        repeat (3) tick();
        chk("reset busy/done", {busy, done}, 2'b00);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat, 1'b0);

        // Restart and MTHI while busy must both be ignored.
        run_op("mult inject", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b1);

        // MTHI / MTLO in IDLE.
        hi_we = 1'b1; d1 = 32'h1234;
        tick();
        hi_we = 1'b0;
        chk("mthi idle", hi, 32'h1234);
        lo_we = 1'b1; d1 = 32'h5678;
        tick();
        lo_we = 1'b0;
        chk("mtlo idle", lo, 32'h5678);

        // Strobes together with start: start wins, HI/LO hold until the result lands.
        hi_we = 1'b1; lo_we = 1'b1;
        run_op("start wins", 2'd1, 32'h0000_ABCD, 32'd1, 32'd0, 32'h0000_ABCD, 33, 1'b0);

        // Asynchronous reset in the middle of a divide.
        op = 2'd2; d1 = 32'hFFFF_FF9C; d2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("busy before abort", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort busy/done", {busy, done}, 2'b00);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        chk("no done after abort", dcnt, 0);
        run_op("multu 2x3 after rst", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 33, 1'b0);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            model(ro, ra, rb, reh, rel, rlat);
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, reh, rel, rlat, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
